// File: rtl/p3p_pkg.sv
// rtl/p3p_pkg.sv - shared types and constants for the packet datapath
package p3p_pkg;
    typedef logic signed [15:0] num;
    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;
endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with baud counter
module uart_tx_byte
    import p3p_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [UART_DATA_BITS-1:0] data,
    output logic                      busy,
    output logic                      byte_done,
    output logic                      tx
);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int                BIT_W     = $clog2(UART_DATA_BITS);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]                state;
    logic [BAUD_W-1:0]         baud_cnt;
    logic [BIT_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] cur_byte;
    logic                      bit_end;

    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign busy      = (state != S_IDLE);
    // Combinational so the owner can chain the next start on this very edge.
    assign byte_done = (state == S_STOP) && bit_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            cur_byte <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_byte <= data;
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                        state    <= S_START;
                    end
                end
                default: begin
                    if (!bit_end) begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end else begin
                        baud_cnt <= '0;
                        case (state)
                            S_START: begin
                                state   <= S_DATA;
                                bit_idx <= '0;
                                tx      <= cur_byte[0];
                            end
                            S_DATA: begin
                                if (bit_idx == BIT_LAST) begin
                                    state <= S_STOP;
                                    tx    <= 1'b1;
                                end else begin
                                    bit_idx <= bit_idx + 1'b1;
                                    tx      <= cur_byte[bit_idx + 1'b1];
                                end
                            end
                            default: begin
                                if (start) begin
                                    cur_byte <= data;
                                    tx       <= 1'b0;
                                    state    <= S_START;
                                end else begin
                                    state <= S_IDLE;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/num_packet_tx.sv
// rtl/num_packet_tx.sv - sends a block of 16-bit words as back-to-back UART bytes plus idle gap
module num_packet_tx
    import p3p_pkg::*;
#(
    parameter int n_words      = 2,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int GAP_BITS     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               send_data,
    input  num [n_words-1:0]   tx_words,
    output logic               tx_ready,
    output logic               tx_done,
    output logic               tx
);
    localparam int               N_BYTES    = 2 * n_words;
    localparam int               IDX_W      = $clog2(N_BYTES) + 1;
    localparam logic [IDX_W-1:0] LAST_BYTE  = IDX_W'(N_BYTES - 1);
    localparam int               GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
    localparam int               GAP_W      = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_SEND = 2'd1;
    localparam logic [1:0] P_GAP  = 2'd2;

    logic [1:0]         state;
    num [n_words-1:0]   word_buf;
    logic [IDX_W-1:0]   byte_idx;
    logic [GAP_W-1:0]   gap_cnt;
    logic               accept;
    logic               byte_start;
    logic               byte_busy;
    logic               byte_done;
    logic [7:0]         byte_data;

    // Byte 2k is the low half of word k, byte 2k+1 the high half.
    function automatic logic [7:0] pick_byte(input num [n_words-1:0] words,
                                             input logic [IDX_W-1:0] idx);
        logic [16*n_words-1:0] flat;
        logic [7:0]            r;
        flat = words;
        r    = '0;
        for (int i = 0; i < N_BYTES; i++) begin
            if (idx == IDX_W'(i)) r = flat[8*i +: 8];
        end
        return r;
    endfunction

    assign accept = (state == P_IDLE) && send_data && !byte_busy;

    always_comb begin
        byte_start = 1'b0;
        byte_data  = pick_byte(word_buf, byte_idx + 1'b1);
        case (state)
            P_IDLE: begin
                byte_start = accept;
                byte_data  = tx_words[0][7:0];
            end
            P_SEND:  byte_start = byte_done && (byte_idx != LAST_BYTE);
            default: byte_start = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= P_IDLE;
            word_buf <= '0;
            byte_idx <= '0;
            gap_cnt  <= '0;
            tx_ready <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                P_IDLE: begin
                    if (accept) begin
                        word_buf <= tx_words;
                        byte_idx <= '0;
                        tx_ready <= 1'b0;
                        state    <= P_SEND;
                    end
                end
                P_SEND: begin
                    if (byte_done) begin
                        if (byte_idx == LAST_BYTE) begin
                            gap_cnt <= '0;
                            state   <= P_GAP;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt  <= '0;
                        tx_ready <= 1'b1;
                        tx_done  <= 1'b1;
                        state    <= P_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk      (clk),
        .reset    (reset),
        .start    (byte_start),
        .data     (byte_data),
        .busy     (byte_busy),
        .byte_done(byte_done),
        .tx       (tx)
    );
endmodule
